// File: rtl/int_gateway_pkg.sv
// Shared definitions for the interrupt gateway: source map, per-source state
// encoding and the decoded claim/complete command bundle.
package int_gateway_pkg;

  localparam int INT_BITS           = 4;
  localparam int INT_IDX_DMA_NOTIFY = 0;
  localparam int INT_IDX_DMA_FIN    = 1;
  localparam int INT_IDX_SCTRL      = 2;
  localparam int INT_IDX_EPU        = 3;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  // Claim/complete already decoded against one source's index.
  typedef struct packed {
    logic claim;
    logic complete;
  } gw_cmd_t;

endpackage

// File: rtl/int_gw_src.sv
// One gateway source: synchroniser, edge detect, request register and the
// IDLE/PENDING/ACTIVE lifecycle with a single saturating re-pend flag.
module int_gw_src
  import int_gateway_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  input  gw_cmd_t cmd,
  output logic    pend,
  output logic    act
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   s, s_d, rise, req, req_q, edge_req;
  logic                   repend;
  gw_state_e              state;

  assign s = sync[SYNC_STAGES-1];

  // The chain and s_d come out of reset as zeros, so a line already high would
  // look like a fresh edge; rise is only trusted once s_d holds a real sample.
  assign rise     = s & ~s_d & vld_pipe[SYNC_STAGES];
  assign req      = EDGE ? rise : s;
  assign edge_req = EDGE && req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      s_d      <= 1'b0;
      req_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], raw};
      s_d      <= s;
      req_q    <= req;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GW_IDLE;
      repend <= 1'b0;
    end else begin
      case (state)
        GW_IDLE: begin
          if (req_q) state <= GW_PENDING;
        end
        GW_PENDING: begin
          if (edge_req)  repend <= 1'b1;
          if (cmd.claim) state  <= GW_ACTIVE;
        end
        GW_ACTIVE: begin
          if (cmd.complete) begin
            // An edge arriving with the completion is served, not lost.
            state  <= (repend || edge_req) ? GW_PENDING : GW_IDLE;
            repend <= 1'b0;
          end else if (edge_req) begin
            repend <= 1'b1;
          end
        end
        default: begin
          state  <= GW_IDLE;
          repend <= 1'b0;
        end
      endcase
    end
  end

  assign pend = (state == GW_PENDING);
  assign act  = (state == GW_ACTIVE);

endmodule

// File: rtl/int_gateway.sv
// Interrupt gateway in front of the PLIC: per-source lifecycle plus an output
// mask that keeps bits [INT_BITS-1:1] one-hot and silent during service.
module int_gateway #(
  parameter int                  INT_BITS    = int_gateway_pkg::INT_BITS,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [INT_BITS-1:0] EDGE_MASK   = INT_BITS'(4'b0011)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INT_BITS-1:0]         irq_raw_i,
  input  logic                        claim_i,
  input  logic [$clog2(INT_BITS)-1:0] claim_idx_i,
  input  logic                        complete_i,
  input  logic [$clog2(INT_BITS)-1:0] complete_idx_i,
  output logic [INT_BITS-1:0]         interrupt_o,
  output logic [INT_BITS-1:0]         active_o
);
  import int_gateway_pkg::*;

  localparam int IDX_W = $clog2(INT_BITS);

  gw_cmd_t [INT_BITS-1:0] cmd;
  logic    [INT_BITS-1:0] pend, act, irq;

  // Indices past INT_BITS-1 match no source and are dropped here.
  always_comb begin
    cmd = '0;
    for (int i = 0; i < INT_BITS; i++) begin
      cmd[i].claim    = claim_i    && (claim_idx_i    == IDX_W'(i));
      cmd[i].complete = complete_i && (complete_idx_i == IDX_W'(i));
    end
  end

  for (genvar i = 0; i < INT_BITS; i++) begin : g_src
    int_gw_src #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[i])
    ) u_src (
      .clk  (clk),
      .rst  (rst),
      .raw  (irq_raw_i[i]),
      .cmd  (cmd[i]),
      .pend (pend[i]),
      .act  (act[i])
    );
  end

  // Source 0 bypasses the mask; the upper group presents only its highest
  // pending member, and nothing at all while one of them is in service.
  always_comb begin
    irq    = '0;
    irq[0] = pend[0];
    if (!(|act[INT_BITS-1:1])) begin
      for (int i = 1; i < INT_BITS; i++) begin
        if (pend[i]) begin
          irq[INT_BITS-1:1] = '0;
          irq[i]            = 1'b1;
        end
      end
    end
  end

  assign interrupt_o = irq;
  assign active_o    = act;

endmodule

// File: doc/int_gateway.md
# int_gateway

Interrupt source gateway sitting directly upstream of the PLIC. It synchronises the raw peripheral interrupt lines (DMA_notify, DMA_fin, SCtrl, EPU) into clk and converts edge- or level-type requests into held pending bits. It tracks each source through a claim/complete lifecycle and drives the PLIC's `interrupt_i` vector. That vector is one-hot across bits [3:1], so the PLIC's ID decode never sees two service requests at once.

## Interface
- `INT_BITS`, default 4: number of sources. Bit map: 3 EPU, 2 SCtrl, 1 DMA_fin, 0 DMA_notify.
- `SYNC_STAGES`, default 2: synchroniser flops per raw line, minimum 2.
- `EDGE_MASK`, default 4'b0011: bit=1 means the source is rising-edge triggered; bit=0 means level-high.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset: asynchronous, active-high. Clock is `clk`.
- `irq_raw_i`  in  INT_BITS  asynchronous peripheral interrupt lines.
- `claim_i`  in  1  one-cycle pulse: the core has taken the interrupt identified by `claim_idx_i`.
- `claim_idx_i`  in  $clog2(INT_BITS)  source index being claimed.
- `complete_i`  in  1  one-cycle pulse: the handler for `complete_idx_i` has finished (issued on mret).
- `complete_idx_i`  in  $clog2(INT_BITS)  source index being completed.
- `interrupt_o`  out  INT_BITS  request vector to the PLIC `interrupt_i`.
- `active_o`  out  INT_BITS  debug: sources currently in service.

## Operation
- Synchroniser: each line passes through SYNC_STAGES flops, giving `s`. A further flop `s_d` feeds edge detection: `rise = s & ~s_d`.
- Request term per source:
  - edge sources: `req = rise`
  - level sources: `req = s`
- Per-source FSM, states IDLE, PENDING, ACTIVE:
  - IDLE -> PENDING on `req`.
  - PENDING -> ACTIVE on `claim_i` with a matching index.
  - ACTIVE -> IDLE on `complete_i` with a matching index.
  - A level source that is still high moves IDLE -> PENDING on the next cycle it is evaluated, so there is no lost or duplicated service.
- Edge sources in PENDING or ACTIVE: an additional `rise` sets a 1-bit `repend` flag (saturating, extra edges are dropped). On completion with `repend` set, the next state is PENDING instead of IDLE, and `repend` clears.
- Ignored requests:
  - claim for a source not in PENDING
  - complete for a source not in ACTIVE
  - either with an index >= INT_BITS
- Output masking:
  - `interrupt_o[0] = (state0 == PENDING)`.
  - Bits [3:1] carry only the highest-index PENDING source among 1..3. The others stay 0 until it leaves PENDING.
  - While any of sources 1..3 is ACTIVE, bits [3:1] are all 0 (no nesting).
- `active_o[i] = (state_i == ACTIVE)`.
- Simultaneous events:
  - claim and complete in the same cycle on different indices both take effect.
  - Same index in both: the transition from the current state wins, and the other request is ignored that cycle.
  - `req` and complete in the same cycle on an edge source: ends in PENDING.

## Timing
- Reset: all FSMs IDLE, sync chain, `s_d` and `repend` cleared. `interrupt_o = 0`, `active_o = 0`.
- Asserting `rst` mid-service drops all pending and active state immediately. After release, a level line that is still high re-pends. An edge line does not, because its edge was lost.
- Latency: a raw rising edge sampled at edge k appears on `interrupt_o` after edge k+SYNC_STAGES+1 (3 cycles by default).
- `interrupt_o` is combinational from FSM state only, with no input-to-output combinational path.
- Claim takes effect at the next clock edge: `interrupt_o` for that source drops one cycle after `claim_i`.
- A masked lower-priority source appears the cycle after the higher one is completed.
- Raw pulses shorter than one clk period may be missed. Peripherals hold lines for at least 2 clk periods.

## Structure
- `CPU_def`/shared package: `INT_BITS`, source index constants (`INT_IDX_DMA_NOTIFY=0`, `INT_IDX_DMA_FIN=1`, `INT_IDX_SCTRL=2`, `INT_IDX_EPU=3`), and the enum `gw_state_e {GW_IDLE, GW_PENDING, GW_ACTIVE}`.
- Sub-module `int_gw_src`: synchroniser, edge detect, FSM and `repend` for one source, parameterised by `SYNC_STAGES` and `EDGE`.
- `int_gateway` instantiates INT_BITS copies via generate and implements the output priority mask.

## Test plan
- Level SCtrl (bit 2) raised at cycle 10 and held -> `interrupt_o = 4'b0100` from cycle 13. Claim idx 2 -> `interrupt_o = 0`, `active_o = 4'b0100`. Complete idx 2 with line still high -> `interrupt_o = 4'b0100` again, no gap beyond 1 cycle.
- DMA_fin edge, then a second edge while ACTIVE -> claim/complete once -> source re-pends exactly once. A third edge while ACTIVE (with `repend` already set) is dropped -> after the second completion, `interrupt_o[1] = 0`.
- EPU and SCtrl pend in the same cycle -> `interrupt_o = 4'b1000`. Claim and complete 3 -> `4'b0100` on the following cycle.
- DMA_notify pending while EPU is ACTIVE -> `interrupt_o = 4'b0001`, and bits [3:1] stay 0.
- Claim idx 1 while source 1 is IDLE, and complete idx 3 while source 3 is PENDING -> no state change; `interrupt_o` unchanged.
- `rst` asserted with sources 2 ACTIVE and 0 PENDING -> all outputs 0 within the same cycle. Level line 2 still high after release -> `interrupt_o = 4'b0100` after 3 cycles.
